// File: rtl/iterative_chunk_adder.sv
// iterative_chunk_adder: multi-cycle add/subtract, CHUNK bits per clock, with valid/ready handshakes
module iterative_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 2 || WIDTH % CHUNK != 0) begin : g_bad_params
        $error("iterative_chunk_adder: WIDTH must be >= 2 and divisible by CHUNK");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CHUNK:0]   part;
    logic             last;

    always_comb begin
        part = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]} + {1'b0, b_q[cnt_q*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry_q};
        last = cnt_q == CW'(NCHUNK - 1);
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        sum_d = sum_q;
        carry_d = carry_q;
        cout_d = cout_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (state_q == IDLE && in_valid) begin
            a_d = in_a;
            b_d = in_sub ? ~in_b : in_b;
            carry_d = in_sub ^ in_cin;
            cnt_d = '0;
            state_d = BUSY;
        end else if (state_q == BUSY) begin
            sum_d[cnt_q*CHUNK +: CHUNK] = part[CHUNK-1:0];
            carry_d = part[CHUNK];
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                cout_d = part[CHUNK];
                // carry into the MSB is recovered as a^b^sum at that bit
                ovf_d = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ part[CHUNK-1] ^ part[CHUNK];
                state_d = DONE;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
            carry_q <= 1'b0;
            cout_q <= 1'b0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            sum_q <= sum_d;
            carry_q <= carry_d;
            cout_q <= cout_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_sum = sum_q;
    assign out_cout = cout_q;
    assign out_ovf = ovf_q;
endmodule

// File: tb/tb_iterative_chunk_adder.sv
// tb_iterative_chunk_adder: table, corner-case and random scoreboard checks of iterative_chunk_adder
module tb_iterative_chunk_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    bit rnd_on = 1'b0;

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] s; logic c; logic o;} res8_t;
    typedef struct packed {logic [15:0] s; logic c; logic o;} res16_t;
    typedef struct {logic [7:0] a; logic [7:0] b; logic cin; logic sub; res8_t r;} vec8_t;

    logic i8_valid = 1'b0, i8_cin = 1'b0, i8_sub = 1'b0, o8_ready = 1'b1;
    logic i8_ready, o8_valid, o8_cout, o8_ovf;
    logic [7:0] i8_a = '0, i8_b = '0, o8_sum;

    logic i16_valid = 1'b0, i16_cin = 1'b0, i16_sub = 1'b0, o16_ready = 1'b1;
    logic i16_ready, o16_valid, o16_cout, o16_ovf;
    logic [15:0] i16_a = '0, i16_b = '0, o16_sum;

    logic i2_valid = 1'b0, i2_cin = 1'b0;
    logic [1:0] i2_a = '0, i2_b = '0;
    logic r2a, r2b, o2a_valid, o2b_valid, o2a_cout, o2b_cout, o2a_ovf, o2b_ovf;
    logic [1:0] o2a_sum, o2b_sum;

    res8_t q8[$];
    res16_t q16[$];
    vec8_t vecs[10];

    iterative_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(i8_valid), .in_ready(i8_ready), .in_a(i8_a), .in_b(i8_b),
        .in_cin(i8_cin), .in_sub(i8_sub), .out_valid(o8_valid), .out_ready(o8_ready), .out_sum(o8_sum),
        .out_cout(o8_cout), .out_ovf(o8_ovf));

    iterative_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(i16_valid), .in_ready(i16_ready), .in_a(i16_a), .in_b(i16_b),
        .in_cin(i16_cin), .in_sub(i16_sub), .out_valid(o16_valid), .out_ready(o16_ready), .out_sum(o16_sum),
        .out_cout(o16_cout), .out_ovf(o16_ovf));

    iterative_chunk_adder #(.WIDTH(2), .CHUNK(1)) dut2a (
        .clk(clk), .rst_n(rst_n), .in_valid(i2_valid), .in_ready(r2a), .in_a(i2_a), .in_b(i2_b),
        .in_cin(i2_cin), .in_sub(1'b0), .out_valid(o2a_valid), .out_ready(1'b1), .out_sum(o2a_sum),
        .out_cout(o2a_cout), .out_ovf(o2a_ovf));

    iterative_chunk_adder #(.WIDTH(2), .CHUNK(2)) dut2b (
        .clk(clk), .rst_n(rst_n), .in_valid(i2_valid), .in_ready(r2b), .in_a(i2_a), .in_b(i2_b),
        .in_cin(i2_cin), .in_sub(1'b0), .out_valid(o2b_valid), .out_ready(1'b1), .out_sum(o2b_sum),
        .out_cout(o2b_cout), .out_ovf(o2b_ovf));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic res16_t model16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        logic [15:0] bb;
        logic ci;
        logic [16:0] t;
        bb = sub ? ~b : b;
        ci = sub ^ cin;
        t = {1'b0, a} + {1'b0, bb} + {16'd0, ci};
        model16.s = t[15:0];
        model16.c = t[16];
        model16.o = (a[15] == bb[15]) && (t[15] != a[15]);
    endfunction

    always @(negedge clk) begin
        if (rst_n && o8_valid && o8_ready) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut8_unexpected actual=%0h required=none", o8_sum);
            end else begin
                chk("dut8_sum", 32'(o8_sum), 32'(q8[0].s));
                chk("dut8_cout", 32'(o8_cout), 32'(q8[0].c));
                chk("dut8_ovf", 32'(o8_ovf), 32'(q8[0].o));
                void'(q8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && o16_valid && o16_ready) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut16_unexpected actual=%0h required=none", o16_sum);
            end else begin
                chk("dut16_result", 32'({o16_sum, o16_cout, o16_ovf}), 32'(q16[0]));
                void'(q16.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        o16_ready = rnd_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send8(input vec8_t v);
        int n = 0;
        @(posedge clk);
        #1;
        i8_a = v.a;
        i8_b = v.b;
        i8_cin = v.cin;
        i8_sub = v.sub;
        i8_valid = 1'b1;
        @(negedge clk);
        while (!i8_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("dut8_accept", 32'(i8_ready), 32'd1);
        if (i8_ready) q8.push_back(v.r);
        @(posedge clk);
        #1;
        i8_valid = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("dut8_drain", 32'(q8.size()), 32'd0);
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        int n = 0;
        @(posedge clk);
        #1;
        i16_a = a;
        i16_b = b;
        i16_cin = cin;
        i16_sub = sub;
        i16_valid = 1'b1;
        @(negedge clk);
        while (!i16_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("dut16_accept", 32'(i16_ready), 32'd1);
        if (i16_ready) q16.push_back(model16(a, b, cin, sub));
        @(posedge clk);
        #1;
        i16_valid = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, '{8'h96, 1'b0, 1'b1}};
        vecs[1] = '{8'h10, 8'h20, 1'b0, 1'b1, '{8'hF0, 1'b0, 1'b0}};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, '{8'h01, 1'b1, 1'b0}};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b1}};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, '{8'h7F, 1'b1, 1'b1}};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b1, '{8'hFF, 1'b0, 1'b0}};
        vecs[6] = '{8'h33, 8'h33, 1'b0, 1'b1, '{8'h00, 1'b1, 1'b0}};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 1'b0, '{8'h00, 1'b1, 1'b0}};
        vecs[8] = '{8'h80, 8'h80, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b1}};
        vecs[9] = '{8'h64, 8'h9C, 1'b0, 1'b1, '{8'hC8, 1'b0, 1'b1}};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(i8_ready), 32'd1);
        chk("reset_out_valid", 32'(o8_valid), 32'd0);
        chk("reset_sum", 32'(o8_sum), 32'd0);
        chk("reset_cout", 32'(o8_cout), 32'd0);
        chk("reset_ovf", 32'(o8_ovf), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            send8(vecs[i]);
            drain8();
        end

        o8_ready = 1'b0;
        send8(vecs[0]);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lat_busy_valid", 32'(o8_valid), 32'd0);
            chk("lat_busy_ready", 32'(i8_ready), 32'd0);
        end
        @(negedge clk);
        chk("lat_done_valid", 32'(o8_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(o8_valid), 32'd1);
            chk("bp_in_ready", 32'(i8_ready), 32'd0);
            chk("bp_sum", 32'(o8_sum), 32'h96);
            chk("bp_cout", 32'(o8_cout), 32'd0);
            chk("bp_ovf", 32'(o8_ovf), 32'd1);
        end
        @(posedge clk);
        #1;
        o8_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 32'(i8_ready), 32'd1);
        chk("bp_release_valid", 32'(o8_valid), 32'd0);
        chk("retain_sum", 32'(o8_sum), 32'h96);
        drain8();

        send8('{8'h12, 8'h34, 1'b0, 1'b0, '{8'h46, 1'b0, 1'b0}});
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", 32'(o8_valid), 32'd0);
        chk("midreset_in_ready", 32'(i8_ready), 32'd1);
        chk("midreset_sum", 32'(o8_sum), 32'd0);
        q8.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send8('{8'hC3, 8'h4E, 1'b1, 1'b1, '{8'h74, 1'b1, 1'b1}});
        drain8();
        repeat (8) @(negedge clk);

        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    logic [2:0] e;
                    bit got_a, got_b;
                    int n;
                    e = 3'(a + b + c);
                    got_a = 1'b0;
                    got_b = 1'b0;
                    n = 0;
                    @(posedge clk);
                    #1;
                    i2_a = 2'(a);
                    i2_b = 2'(b);
                    i2_cin = 1'(c);
                    i2_valid = 1'b1;
                    @(negedge clk);
                    chk("w2_ready", 32'({r2a, r2b}), 32'd3);
                    @(posedge clk);
                    #1;
                    i2_valid = 1'b0;
                    while (!(got_a && got_b) && n < 10) begin
                        @(negedge clk);
                        n++;
                        if (o2a_valid) begin
                            chk("w2c1_result", 32'({o2a_cout, o2a_sum}), 32'(e));
                            got_a = 1'b1;
                        end
                        if (o2b_valid) begin
                            chk("w2c2_result", 32'({o2b_cout, o2b_sum}), 32'(e));
                            got_b = 1'b1;
                        end
                    end
                    chk("w2_done", 32'({got_a, got_b}), 32'd3);
                end
            end
        end

        rnd_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        begin
            int n = 0;
            while (q16.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("dut16_drain", 32'(q16.size()), 32'd0);
        end
        rnd_on = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
